// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants, operation encodings and FSM state type for the
// mdu32 multiply/divide unit.
package mdu_pkg;

   localparam int XLEN  = 32;   // operand/result width (only 32 supported)
   localparam int ITER  = 32;   // radix-2 steps per operation
   localparam int CNT_W = 6;    // iteration counter width, holds XLEN+1

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate. Used as abs() on the
// operands and as the sign fixup on the product, quotient and remainder.
module mdu_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] din,
   input  logic         neg,
   output logic [W-1:0] dout
);

   assign dout = neg ? -din : din;

endmodule

// File: rtl/mdu32.sv
// mdu32: iterative 32-bit multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, one step
// per cycle; MTHI/MTLO write HI/LO directly from A.
// Optional macro MDU_DIV0_FAST_EN: a divide by zero completes on the START
// edge without iterating and pulses DIV0 together with DONE.
module mdu32
   import mdu_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [2:0]      OP,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            BUSY,
   output logic            DONE,
   output logic            DIV0,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;

   // operation context captured at START
   logic [2:0]            op_q;
   logic                  sign_a_q, sign_b_q, div0_q;
   logic [XLEN-1:0]       mag_b_q, a_orig_q;
   logic [2*XLEN-1:0]     acc_q, acc_next;

   logic [XLEN-1:0]       hi_q, lo_q, hi_res, lo_res;
   logic                  done_q;

   logic                  load, fix_wr, fast_div0, wr_hi_a, wr_lo_a, div0_skip;
   logic                  signed_req, res_signed, neg_q;
   logic [XLEN-1:0]       mag_a, mag_b, quo, rem;
   logic [2*XLEN-1:0]     prod;
   logic [XLEN:0]         mul_sum, rem_sh, div_diff;
   logic                  div_ok;

`ifdef MDU_DIV0_FAST_EN
   assign div0_skip = (B == '0);
`else
   assign div0_skip = 1'b0;
`endif

   // operand magnitudes for the signed ops (OP[0]=0 means signed)
   assign signed_req = ~OP[0];

   mdu_sign_fix #(.W(XLEN)) u_abs_a (.din(A), .neg(signed_req & A[XLEN-1]), .dout(mag_a));
   mdu_sign_fix #(.W(XLEN)) u_abs_b (.din(B), .neg(signed_req & B[XLEN-1]), .dout(mag_b));

   // result sign fixup; the remainder follows the dividend's sign
   assign res_signed = ~op_q[0];
   assign neg_q      = res_signed & (sign_a_q ^ sign_b_q);

   mdu_sign_fix #(.W(2*XLEN)) u_fix_prod (.din(acc_q), .neg(neg_q), .dout(prod));
   mdu_sign_fix #(.W(XLEN)) u_fix_quo (.din(acc_q[XLEN-1:0]), .neg(neg_q), .dout(quo));
   mdu_sign_fix #(.W(XLEN)) u_fix_rem (.din(acc_q[2*XLEN-1:XLEN]),
                                       .neg(res_signed & sign_a_q), .dout(rem));

   // next-state and control strobes
   // NOTE: every output of this block gets a default first so no path leaves
   // it unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      fix_wr    = 1'b0;
      fast_div0 = 1'b0;
      wr_hi_a   = 1'b0;
      wr_lo_a   = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               case (OP)
                  OP_MULT, OP_MULTU: begin
                     load    = 1'b1;
                     state_d = CALC;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (div0_skip) begin
                        fast_div0 = 1'b1;
                     end else begin
                        load    = 1'b1;
                        state_d = CALC;
                     end
                  end
                  OP_MTHI: wr_hi_a = 1'b1;
                  OP_MTLO: wr_lo_a = 1'b1;
                  default: ;
               endcase
            end
         end
         CALC: begin
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            fix_wr  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // one radix-2 step: multiply adds B into the upper half then shifts right;
   // divide shifts the next dividend bit into the remainder and subtracts
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_b_q : '0)};
      rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff = rem_sh - {1'b0, mag_b_q};
      div_ok   = ~div_diff[XLEN];
      if (op_q[1]) begin
         acc_next = {(div_ok ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ok};
      end else begin
         acc_next = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // final HI/LO values; a zero divisor overrides the iterated result
   always_comb begin
      hi_res = prod[2*XLEN-1:XLEN];
      lo_res = prod[XLEN-1:0];
      if (op_q[1]) begin
         if (div0_q) begin
            hi_res = a_orig_q;
            lo_res = '1;
         end else begin
            hi_res = rem;
            lo_res = quo;
         end
      end
   end

   // state register and iteration counter
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load)                cnt_q <= '0;
         else if (state_q == CALC) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // operand capture and accumulator
   // NOTE: these datapath registers carry no reset; they are always loaded
   // before use and their contents are ignored while IDLE.
   always_ff @(posedge CLK) begin
      if (load) begin
         op_q     <= OP;
         sign_a_q <= A[XLEN-1];
         sign_b_q <= B[XLEN-1];
         mag_b_q  <= mag_b;
         a_orig_q <= A;
         div0_q   <= (B == '0);
         acc_q    <= {{XLEN{1'b0}}, mag_a};
      end else if (state_q == CALC) begin
         acc_q    <= acc_next;
      end
   end

   // HI/LO result registers and DONE pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= fix_wr | fast_div0;
         if (fix_wr) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
         end else if (fast_div0) begin
            hi_q <= A;
            lo_q <= '1;
         end else begin
            if (wr_hi_a) hi_q <= A;
            if (wr_lo_a) lo_q <= A;
         end
      end
   end

`ifdef MDU_DIV0_FAST_EN
   logic div0_pulse_q;

   // DIV0 pulse alongside the fast divide-by-zero DONE
   always_ff @(posedge CLK) begin
      if (RST) div0_pulse_q <= 1'b0;
      else     div0_pulse_q <= fast_div0;
   end

   assign DIV0 = div0_pulse_q;
`else
   assign DIV0 = 1'b0;
`endif

   assign BUSY = (state_q != IDLE);
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: directed self-checking bench for mdu32. Inputs are driven and
// outputs sampled on the falling clock edge; cycle 0 is the START cycle.
module tb_mdu32;
   import mdu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST, START;
   logic [2:0]  OP;
   logic [31:0] A, B;
   logic        BUSY, DONE, DIV0;
   logic [31:0] HI, LO;

   int n_checks = 0;
   int n_fail   = 0;

   mdu32 dut (
      .CLK (CLK),  .RST (RST),   .START(START), .OP(OP), .A(A), .B(B),
      .BUSY(BUSY), .DONE(DONE),  .DIV0 (DIV0),  .HI(HI), .LO(LO)
   );

   always #5 CLK = ~CLK;

   // present one START cycle, then scramble A/B; returns at the cycle-1 sample point
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      START = 1'b1; OP = op; A = a; B = b;
      @(negedge CLK);
      START = 1'b0; A = ~a; B = ~b;
   endtask

   // count cycles from cycle 1 until DONE; bounded
   task automatic wait_done(output int lat, output int busy);
      lat = 1; busy = 0;
      while (DONE !== 1'b1 && lat < 100) begin
         if (BUSY === 1'b1) busy++;
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      bit seen_done;
      RST = 1'b1; START = 1'b0; OP = 3'b000; A = '0; B = '0;
      repeat (2) @(negedge CLK);
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset BUSY: observed %b expected 0", BUSY); end
      n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset DONE: observed %b expected 0", DONE); end
      n_checks++; if (DIV0 !== 1'b0) begin n_fail++; $display("FAIL reset DIV0: observed %b expected 0", DIV0); end
      n_checks++; if (HI !== 32'h0)  begin n_fail++; $display("FAIL reset HI: observed %h expected 0", HI); end
      n_checks++; if (LO !== 32'h0)  begin n_fail++; $display("FAIL reset LO: observed %h expected 0", LO); end
      RST = 1'b0;
      @(negedge CLK);
      issue(OP_MTHI, 32'h1111_1111, 32'h0);
      issue(OP_MTLO, 32'h2222_2222, 32'h0);
      n_checks++; if (HI !== 32'h1111_1111) begin n_fail++; $display("FAIL preload HI: observed %h expected 11111111", HI); end
      n_checks++; if (LO !== 32'h2222_2222) begin n_fail++; $display("FAIL preload LO: observed %h expected 22222222", LO); end
      // abort a multiply in cycle 10
      issue(OP_MULT, 32'd3, 32'd5);
      repeat (9) @(negedge CLK);
      n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL abort BUSY before reset: observed %b expected 1", BUSY); end
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL abort BUSY: observed %b expected 0", BUSY); end
      n_checks++; if (HI !== 32'h0)  begin n_fail++; $display("FAIL abort HI: observed %h expected 0", HI); end
      n_checks++; if (LO !== 32'h0)  begin n_fail++; $display("FAIL abort LO: observed %h expected 0", LO); end
      seen_done = 1'b0;
      repeat (40) begin
         if (DONE === 1'b1) seen_done = 1'b1;
         @(negedge CLK);
      end
      n_checks++; if (seen_done) begin n_fail++; $display("FAIL abort DONE: observed pulse expected none"); end
   endtask

   task automatic test_arith();
      logic [2:0]  top[5] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV};
      logic [31:0] ta[5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
      logic [31:0] tb[5]  = '{32'd7, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFFF};
      logic [31:0] thi[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'h0};
      logic [31:0] tlo[5] = '{32'hFFFF_FFEB, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000};
      string       tn[5]  = '{"MULT -3*7", "MULTU max*max", "DIV -7/2", "DIVU 100/7", "DIV ovf"};
      int lat, busy;
      for (int i = 0; i < 5; i++) begin
         issue(top[i], ta[i], tb[i]);
         wait_done(lat, busy);
         n_checks++; if (lat !== 34)   begin n_fail++; $display("FAIL %s latency: observed %0d expected 34", tn[i], lat); end
         n_checks++; if (busy !== 33)  begin n_fail++; $display("FAIL %s busy cycles: observed %0d expected 33", tn[i], busy); end
         n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL %s BUSY at DONE: observed %b expected 0", tn[i], BUSY); end
         n_checks++; if (HI !== thi[i]) begin n_fail++; $display("FAIL %s HI: observed %h expected %h", tn[i], HI, thi[i]); end
         n_checks++; if (LO !== tlo[i]) begin n_fail++; $display("FAIL %s LO: observed %h expected %h", tn[i], LO, tlo[i]); end
         n_checks++; if (DIV0 !== 1'b0) begin n_fail++; $display("FAIL %s DIV0: observed %b expected 0", tn[i], DIV0); end
         @(negedge CLK);
         n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL %s DONE width: observed %b expected 0", tn[i], DONE); end
      end
   endtask

   task automatic test_div0();
      logic [2:0]  top[2] = '{OP_DIVU, OP_DIV};
      logic [31:0] ta[2]  = '{32'h0000_1234, 32'hFFFF_FFFB};
      string       tn[2]  = '{"DIVU by 0", "DIV by 0"};
      int lat, busy, exp_lat, exp_busy;
      logic exp_div0;
`ifdef MDU_DIV0_FAST_EN
      exp_lat = 1;  exp_busy = 0;  exp_div0 = 1'b1;
`else
      exp_lat = 34; exp_busy = 33; exp_div0 = 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
         issue(top[i], ta[i], 32'h0);
         wait_done(lat, busy);
         n_checks++; if (lat !== exp_lat)   begin n_fail++; $display("FAIL %s latency: observed %0d expected %0d", tn[i], lat, exp_lat); end
         n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL %s busy cycles: observed %0d expected %0d", tn[i], busy, exp_busy); end
         n_checks++; if (HI !== ta[i])      begin n_fail++; $display("FAIL %s HI: observed %h expected %h", tn[i], HI, ta[i]); end
         n_checks++; if (LO !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL %s LO: observed %h expected ffffffff", tn[i], LO); end
         n_checks++; if (DIV0 !== exp_div0) begin n_fail++; $display("FAIL %s DIV0: observed %b expected %b", tn[i], DIV0, exp_div0); end
         @(negedge CLK);
         n_checks++; if (DIV0 !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL %s pulse width: observed DONE=%b DIV0=%b expected 0/0", tn[i], DONE, DIV0); end
      end
   endtask

   task automatic test_ignored_start();
      int lat, busy;
      issue(OP_DIVU, 32'd100, 32'd7);
      lat = 1; busy = 0;
      while (DONE !== 1'b1 && lat < 100) begin
         if (BUSY === 1'b1) busy++;
         START = (lat >= 5 && lat <= 20);
         OP = OP_MULT; A = 32'd3; B = 32'd3;
         @(negedge CLK);
         lat++;
      end
      START = 1'b0;
      n_checks++; if (lat !== 34)  begin n_fail++; $display("FAIL ignored start latency: observed %0d expected 34", lat); end
      n_checks++; if (busy !== 33) begin n_fail++; $display("FAIL ignored start busy: observed %0d expected 33", busy); end
      n_checks++; if (LO !== 32'd14) begin n_fail++; $display("FAIL ignored start LO: observed %h expected 0000000e", LO); end
      n_checks++; if (HI !== 32'd2)  begin n_fail++; $display("FAIL ignored start HI: observed %h expected 00000002", HI); end
      @(negedge CLK);
      n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ignored start restart: observed BUSY=%b expected 0", BUSY); end
   endtask

   task automatic test_mthi();
      issue(OP_MTHI, 32'hCAFE_BABE, 32'h0);
      n_checks++; if (HI !== 32'hCAFE_BABE) begin n_fail++; $display("FAIL MTHI HI: observed %h expected cafebabe", HI); end
      n_checks++; if (LO !== 32'd14)        begin n_fail++; $display("FAIL MTHI LO hold: observed %h expected 0000000e", LO); end
      n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL MTHI handshake: observed BUSY=%b DONE=%b expected 0/0", BUSY, DONE); end
      @(negedge CLK);
      n_checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_fail++; $display("FAIL MTHI after: observed BUSY=%b DONE=%b expected 0/0", BUSY, DONE); end
   endtask

   task automatic test_back_to_back();
      int lat, busy;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, busy);
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b first latency: observed %0d expected 34", lat); end
      n_checks++; if (HI !== 32'hFFFF_FFFE || LO !== 32'h1) begin n_fail++; $display("FAIL b2b first result: observed %h_%h expected fffffffe_00000001", HI, LO); end
      // new START in the DONE cycle
      issue(OP_DIVU, 32'd100, 32'd7);
      n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b accept: observed BUSY=%b expected 1", BUSY); end
      n_checks++; if (HI !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b HI hold: observed %h expected fffffffe", HI); end
      wait_done(lat, busy);
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b second latency: observed %0d expected 34", lat); end
      n_checks++; if (HI !== 32'd2 || LO !== 32'd14) begin n_fail++; $display("FAIL b2b second result: observed %h_%h expected 00000002_0000000e", HI, LO); end
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_div0();
      test_ignored_start();
      test_mthi();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu32.md
Name: mdu32

Overview:
- Iterative 32-bit multiply/divide unit with HI/LO result registers.
- Sits directly upstream of the writeback-select mux32. HI or LO drives its IN1, and COND is asserted for MFHI/MFLO.
- The control unit stalls the PC while BUSY is high.
- Implements the MIPS-style operations MULT, MULTU, DIV, DIVU, MTHI and MTLO.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN+1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  operation request; sampled only while BUSY=0.
- OP  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others = no-op.
- A  in  32  operand A (multiplicand/dividend, or MTHI/MTLO data).
- B  in  32  operand B (multiplier/divisor).
- BUSY  out  1  high while the state is not IDLE.
- DONE  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- DIV0  out  1  one-cycle pulse with DONE on divide-by-zero; tied 0 without the feature.
- HI  out  32  high word / remainder register.
- LO  out  32  low word / quotient register.

Behaviour:
- Reset (synchronous, RST=1 at an edge): state=IDLE, HI=0, LO=0, DONE=0, DIV0=0, counter=0. RST dominates START.
- RST during CALC/FIX aborts the operation; no DONE is produced.
- States:
  - IDLE: START && OP in {000..011} at an edge latches |A|, |B|, the sign bits and OP, clears the accumulator, sets cnt=0, then goes to CALC.
  - START && OP=100 writes HI=A at that edge and stays IDLE; no BUSY, no DONE. OP=101 writes LO=A the same way.
  - START with OP=110/111 is ignored.
  - CALC: one radix-2 step per cycle, cnt increments, 32 cycles. After the cnt=31 step, go to FIX.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract, producing a 32-bit quotient and 32-bit remainder.
  - FIX: sign correction, write HI/LO, assert DONE for the next cycle, go to IDLE.
- Latency: START high in cycle 0. BUSY is high in cycles 1–33 (CALC 1–32, FIX 33). In cycle 34, DONE=1, BUSY=0 and HI/LO are new.
- DONE and DIV0 are registered and high for exactly one cycle.
- START during BUSY is ignored; A/B changes during BUSY have no effect.
- START in the DONE cycle is accepted, because BUSY=0.
- Signed rules:
  - MULT: 64-bit product negated if sign(A)≠sign(B); {HI,LO}=product.
  - DIV: quotient negated if the signs differ; remainder takes the sign of A. LO=quotient, HI=remainder.
  - Unsigned ops skip the sign handling.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, no trap.
- Divide by zero (B=0, DIV or DIVU): LO=0xFFFFFFFF, HI=A as originally presented, regardless of signedness.
- HI/LO are only written on FIX, MTHI/MTLO or reset; otherwise they hold.

Optional Feature:
- Macro: MDU_DIV0_FAST_EN.
- Defined:
  - DIV/DIVU with B=0 at START skips CALC.
  - The next edge writes HI=A, LO=0xFFFFFFFF, and DONE=DIV0=1 in the following cycle (cycle 1).
  - BUSY is high for 0 cycles beyond the START edge.
- Undefined:
  - A divide by zero runs the full 34-cycle sequence with the same HI/LO results.
  - DIV0 is held 0.

Decomposition:
- Package mdu_pkg:
  - OP encodings (OP_MULT..OP_MTLO).
  - XLEN, ITER=32.
  - State enum IDLE/CALC/FIX.
- Sub-module mdu_sign_fix: combinational conditional two's-complement negate (abs on entry, fixup on exit). It is instantiated for operands and for results.
- FSM, counter and datapath live in mdu32.

Test Plan:
- Reset: RST during CALC (cycle 10) → BUSY=0 next cycle, HI=LO=0, no DONE pulse.
- MULT A=0xFFFFFFFD (−3), B=7 → DONE in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=−7 (0xFFFFFFF9), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 → LO=14, HI=2.
- DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0:
  - With MDU_DIV0_FAST_EN → DONE=DIV0=1 in cycle 1; LO=0xFFFFFFFF, HI=0x1234.
  - Without the macro → DONE in cycle 34 with the same HI/LO.
- Handshake:
  - START re-asserted in cycles 5–20 → ignored.
  - MTHI A=0xCAFEBABE while idle → HI updated next cycle, no BUSY/DONE.
  - START in the DONE cycle → new operation accepted and BUSY in the next cycle.
